frv_mmio_bridge: RTL

Data-side bus splitter between the core's data memory port and the counter/timer MMIO port. It routes each core request either to external memory (pass-through, pipelined) or to the MMIO slave (mtime/mtimecmp), keeps responses in order, and buffers the one-cycle MMIO read result. It also turns sub-word MMIO writes into read-modify-write sequences, because the MMIO slave only accepts full 32-bit writes.

---
 rtl/frv_mmio_bridge.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/frv_mmio_bridge.sv
// Data-side splitter: routes core requests to external memory (pass-through) or the
// mtime/mtimecmp MMIO slave, keeping responses in order and widening sub-word MMIO writes.
module frv_mmio_bridge #(
  parameter logic [31:0] MMIO_BASE_ADDR = 32'h0000_1000,
  parameter logic [31:0] MMIO_BASE_MASK = 32'hFFFF_F000,
  parameter int unsigned OUTSTANDING    = 2
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        c_req,
  input  logic        c_wen,
  input  logic [3:0]  c_strb,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_recv,
  input  logic        c_ack,
  output logic        c_error,
  output logic [31:0] c_rdata,
  output logic        m_req,
  output logic        m_wen,
  output logic [3:0]  m_strb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_recv,
  input  logic        m_error,
  output logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        mmio_en,
  output logic        mmio_wen,
  output logic [31:0] mmio_addr,
  output logic [31:0] mmio_wdata,
  input  logic [31:0] mmio_rdata,
  input  logic        mmio_error
);

  typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, WAIT, RSP} state_t;

  localparam logic [2:0] CNT_MAX = 3'(OUTSTANDING);

  state_t      state, state_d;
  logic [2:0]  cnt;
  logic        wen_q;
  logic [3:0]  strb_q;
  logic [31:2] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rsp_rdata, rsp_rdata_d;
  logic        rsp_err, rsp_err_d, rsp_load;
  logic [31:0] merged_wdata;

  logic hit, idle, rsp_sel, hit_acc, mem_issue, mem_ret;

  assign hit     = ((c_addr & MMIO_BASE_MASK) == (MMIO_BASE_ADDR & MMIO_BASE_MASK));
  assign idle    = (state == IDLE);
  // Reset gating keeps outputs quiet even while the old state is still in the register.
  assign rsp_sel = g_resetn && (state == RSP);

  assign m_req   = g_resetn && c_req && !hit && idle && (cnt < CNT_MAX);
  assign m_wen   = c_wen;
  assign m_strb  = c_strb;
  assign m_addr  = c_addr;
  assign m_wdata = c_wdata;

  assign c_gnt     = hit ? (g_resetn && idle && (cnt == 3'd0)) : (m_req && m_gnt);
  assign hit_acc   = c_req && c_gnt && hit;
  assign mem_issue = m_req && m_gnt;
  assign mem_ret   = m_recv && m_ack;

  assign m_ack   = rsp_sel ? 1'b0 : c_ack;
  assign c_recv  = rsp_sel ? 1'b1 : m_recv;
  assign c_rdata = rsp_sel ? rsp_rdata : m_rdata;
  assign c_error = rsp_sel ? rsp_err : m_error;

  assign mmio_addr = {addr_q, 2'b00};

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      cnt <= 3'd0;
    end else if (mem_issue && !mem_ret) begin
      cnt <= cnt + 3'd1;
    end else if (!mem_issue && mem_ret) begin
      cnt <= cnt - 3'd1;
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      wen_q   <= 1'b0;
      strb_q  <= 4'h0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
    end else if (hit_acc) begin
      wen_q   <= c_wen;
      strb_q  <= c_strb;
      addr_q  <= c_addr[31:2];
      wdata_q <= c_wdata;
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (rsp_load) begin
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

  // Bytes not being written come from the word just read back in RMW_RD.
  always_comb begin
    merged_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      merged_wdata[i*8 +: 8] = strb_q[i] ? wdata_q[i*8 +: 8] : mmio_rdata[i*8 +: 8];
    end
  end

  always_comb begin
    state_d     = state;
    mmio_en     = 1'b0;
    mmio_wen    = 1'b0;
    mmio_wdata  = 32'h0;
    rsp_load    = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;
    case (state)
      IDLE: begin
        if (hit_acc) begin
          if (!c_wen || (c_strb == 4'hF)) begin
            state_d = ACCESS;
          end else if (c_strb != 4'h0) begin
            state_d = RMW_RD;
          end else begin
            state_d  = RSP;
            rsp_load = 1'b1;
          end
        end
      end
      ACCESS: begin
        mmio_en    = 1'b1;
        mmio_wen   = wen_q;
        mmio_wdata = wdata_q;
        state_d    = WAIT;
      end
      RMW_RD: begin
        mmio_en = 1'b1;
        state_d = RMW_WR;
      end
      RMW_WR: begin
        if (mmio_error) begin
          rsp_load  = 1'b1;
          rsp_err_d = 1'b1;
          state_d   = RSP;
        end else begin
          mmio_en    = 1'b1;
          mmio_wen   = 1'b1;
          mmio_wdata = merged_wdata;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        rsp_load    = 1'b1;
        rsp_err_d   = mmio_error;
        rsp_rdata_d = wen_q ? 32'h0 : mmio_rdata;
        state_d     = RSP;
      end
      RSP: begin
        if (c_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!g_resetn) begin
      mmio_en    = 1'b0;
      mmio_wen   = 1'b0;
      mmio_wdata = 32'h0;
    end
  end

endmodule
